// File: rtl/icg_pkg.sv
// Shared definitions for the clock-gating enable controller: FSM state
// encodings and the width helper for the hold/latency down-counter.
package icg_pkg;

  typedef enum logic [1:0] {
    ICG_OFF   = 2'b00,
    ICG_WAKE  = 2'b01,
    ICG_ON    = 2'b10,
    ICG_DRAIN = 2'b11
  } icg_state_t;

  // Bits needed to hold the larger of the two counter reload values.
  function automatic int icg_cnt_w(input int idle_hold, input int wake_lat);
    int m;
    m = (idle_hold > wake_lat) ? idle_hold : wake_lat;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gated_clk_dcnt.sv
// Loadable down-counter used for the idle-hold and wake-latency timers.
// Load wins over decrement; decrement stops at zero.
module gated_clk_dcnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Counter register: reset to zero, load has priority over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gated_clk_en_ctrl.sv
// Producer of the registered enable for one gated clock cell. Keeps the
// clock running while the unit is active, holds it for IDLE_HOLD idle
// cycles before gating, and wakes on demand with a level ready signal.
module gated_clk_en_ctrl
  import icg_pkg::*;
#(
  parameter int IDLE_HOLD = 8,
  parameter int WAKE_LAT  = 2,
  parameter int PERF_W    = 16
) (
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              cp0_yy_clk_en,
  input  logic              pad_yy_icg_scan_en,
  input  logic              busy,
  input  logic              wake_req,
  output logic              wake_ack,
  output logic              module_en,
  output logic [1:0]        clk_state,
  output logic [PERF_W-1:0] perf_gate_cnt
);

  localparam int                CNT_W    = icg_cnt_w(IDLE_HOLD, WAKE_LAT);
  localparam logic [CNT_W-1:0]  IDLE_LD  = CNT_W'(IDLE_HOLD - 1);
  localparam logic [CNT_W-1:0]  WAKE_LD  = CNT_W'(WAKE_LAT - 1);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  icg_state_t       state;
  icg_state_t       state_nxt;
  logic             activity;
  logic             force_on;
  logic             keep;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             gate_off;

  assign activity = busy | wake_req;
  assign force_on = ~cp0_yy_clk_en | pad_yy_icg_scan_en;
  assign keep     = activity | force_on;

  gated_clk_dcnt #(
    .CNT_W(CNT_W)
  ) u_dcnt (
    .clk      (forever_cpuclk),
    .rst      (cpurst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // State register: reset lands in ON so the unit comes up clocked.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state <= ICG_ON;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and counter control; activity beats expiry in DRAIN.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    gate_off     = 1'b0;
    case (state)
      ICG_ON: begin
        if (!keep) begin
          state_nxt    = ICG_DRAIN;
          cnt_load     = 1'b1;
          cnt_load_val = IDLE_LD;
        end
      end
      ICG_DRAIN: begin
        if (keep) begin
          state_nxt = ICG_ON;
        end else if (cnt_zero) begin
          state_nxt = ICG_OFF;
          gate_off  = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ICG_OFF: begin
        if (keep) begin
          state_nxt    = ICG_WAKE;
          cnt_load     = 1'b1;
          cnt_load_val = WAKE_LD;
        end
      end
      ICG_WAKE: begin
        // Wake always runs to completion, even if the request goes away.
        if (cnt_zero) begin
          state_nxt = ICG_ON;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_nxt = ICG_ON;
    endcase
  end

  // Outputs decoded from the state register only, so they are glitch-free.
  always_comb begin
    module_en = (state != ICG_OFF);
    wake_ack  = (state == ICG_ON) || (state == ICG_DRAIN);
    clk_state = state;
  end

  // Saturating count of gate-off events, cleared only by reset.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      perf_gate_cnt <= '0;
    end else if (gate_off && (perf_gate_cnt != PERF_MAX)) begin
      perf_gate_cnt <= perf_gate_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_gated_clk_en_ctrl.sv
// Directed bench for gated_clk_en_ctrl: default-parameter instance for the
// functional scenarios, plus a small instance to reach counter saturation.
module tb_gated_clk_en_ctrl;

  localparam logic [1:0] S_OFF   = 2'b00;
  localparam logic [1:0] S_WAKE  = 2'b01;
  localparam logic [1:0] S_ON    = 2'b10;
  localparam logic [1:0] S_DRAIN = 2'b11;

  logic        clk = 1'b0;
  logic        rst, en, scan, busy, wake_req;
  logic        wake_ack, module_en;
  logic [1:0]  clk_state;
  logic [15:0] perf;

  logic        sat_rst, sat_busy;
  logic        sat_ack, sat_men;
  logic [1:0]  sat_state;
  logic [3:0]  sat_perf;

  int errs   = 0;
  int checks = 0;
  int exp_perf = 0;

  gated_clk_en_ctrl dut (
    .forever_cpuclk     (clk),
    .cpurst             (rst),
    .cp0_yy_clk_en      (en),
    .pad_yy_icg_scan_en (scan),
    .busy               (busy),
    .wake_req           (wake_req),
    .wake_ack           (wake_ack),
    .module_en          (module_en),
    .clk_state          (clk_state),
    .perf_gate_cnt      (perf)
  );

  gated_clk_en_ctrl #(.IDLE_HOLD(1), .WAKE_LAT(1), .PERF_W(4)) dut_sat (
    .forever_cpuclk     (clk),
    .cpurst             (sat_rst),
    .cp0_yy_clk_en      (1'b1),
    .pad_yy_icg_scan_en (1'b0),
    .busy               (sat_busy),
    .wake_req           (1'b0),
    .wake_ack           (sat_ack),
    .module_en          (sat_men),
    .clk_state          (sat_state),
    .perf_gate_cnt      (sat_perf)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_on();
    wake_req = 1'b1;
    repeat (3) step();
    wake_req = 1'b0;
  endtask

  task automatic drain_to_off();
    repeat (1 + 8) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; scan = 1'b0; busy = 1'b0; wake_req = 1'b0;
    step(); step();
    checks++; if (clk_state !== S_ON) begin errs++; $display("FAIL reset_state got=%b exp=%b", clk_state, S_ON); end
    checks++; if (module_en !== 1'b1) begin errs++; $display("FAIL reset_men got=%b exp=1", module_en); end
    checks++; if (wake_ack !== 1'b1) begin errs++; $display("FAIL reset_ack got=%b exp=1", wake_ack); end
    checks++; if (perf !== 16'd0) begin errs++; $display("FAIL reset_perf got=%0d exp=0", perf); end
  endtask

  task automatic test_gate_off();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (clk_state !== S_DRAIN || module_en !== 1'b1)
        begin errs++; $display("FAIL gate_off_hold cyc=%0d got state=%b men=%b exp state=11 men=1", i, clk_state, module_en); end
    end
    step();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || module_en !== 1'b0 || wake_ack !== 1'b0)
      begin errs++; $display("FAIL gate_off_off got state=%b men=%b ack=%b exp 00/0/0", clk_state, module_en, wake_ack); end
    checks++; if (perf !== 16'(exp_perf)) begin errs++; $display("FAIL gate_off_perf got=%0d exp=%0d", perf, exp_perf); end
  endtask

  task automatic test_wake();
    wake_req = 1'b1;
    step();
    checks++; if (clk_state !== S_WAKE || module_en !== 1'b1 || wake_ack !== 1'b0)
      begin errs++; $display("FAIL wake_t1 got state=%b men=%b ack=%b exp 01/1/0", clk_state, module_en, wake_ack); end
    step();
    checks++; if (clk_state !== S_WAKE || wake_ack !== 1'b0)
      begin errs++; $display("FAIL wake_t2 got state=%b ack=%b exp 01/0", clk_state, wake_ack); end
    step();
    checks++; if (clk_state !== S_ON || wake_ack !== 1'b1)
      begin errs++; $display("FAIL wake_t3 got state=%b ack=%b exp 10/1", clk_state, wake_ack); end
    wake_req = 1'b0;
    repeat (8) step();
    checks++; if (module_en !== 1'b1) begin errs++; $display("FAIL wake_drain_hold got men=%b exp=1", module_en); end
    step();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL wake_drain_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_busy_pulse();
    go_on();
    step();
    repeat (4) step();
    busy = 1'b1;
    step();
    busy = 1'b0;
    checks++; if (clk_state !== S_ON) begin errs++; $display("FAIL busy_pulse_on got=%b exp=10", clk_state); end
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++; if (clk_state !== S_DRAIN || perf !== 16'(exp_perf))
        begin errs++; $display("FAIL busy_pulse_drain cyc=%0d got state=%b perf=%0d exp 11/%0d", i, clk_state, perf, exp_perf); end
    end
    step();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL busy_pulse_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_busy_at_expiry();
    go_on();
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (module_en !== 1'b1) begin errs++; $display("FAIL expiry_hold cyc=%0d got men=%b exp=1", i, module_en); end
    end
    busy = 1'b1;
    step();
    busy = 1'b0;
    checks++; if (clk_state !== S_ON || module_en !== 1'b1 || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL expiry_busy got state=%b men=%b perf=%0d exp 10/1/%0d", clk_state, module_en, perf, exp_perf); end
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL expiry_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_wake_no_abort();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    step();
    checks++; if (clk_state !== S_WAKE) begin errs++; $display("FAIL no_abort_wake got=%b exp=01", clk_state); end
    step();
    checks++; if (clk_state !== S_ON || wake_ack !== 1'b1)
      begin errs++; $display("FAIL no_abort_on got state=%b ack=%b exp 10/1", clk_state, wake_ack); end
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL no_abort_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_force_csr();
    en = 1'b0;
    step();
    checks++; if (clk_state !== S_WAKE) begin errs++; $display("FAIL csr_wake got=%b exp=01", clk_state); end
    step(); step();
    for (int i = 0; i < 50; i++) begin
      step();
      checks++; if (clk_state !== S_ON || module_en !== 1'b1)
        begin errs++; $display("FAIL csr_hold cyc=%0d got state=%b men=%b exp 10/1", i, clk_state, module_en); end
    end
    en = 1'b1;
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL csr_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_scan();
    scan = 1'b1;
    step();
    checks++; if (clk_state !== S_WAKE || module_en !== 1'b1)
      begin errs++; $display("FAIL scan_wake got state=%b men=%b exp 01/1", clk_state, module_en); end
    step(); step();
    checks++; if (clk_state !== S_ON) begin errs++; $display("FAIL scan_on got=%b exp=10", clk_state); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++; if (module_en !== 1'b1 || clk_state !== S_ON)
        begin errs++; $display("FAIL scan_hold cyc=%0d got state=%b men=%b exp 10/1", i, clk_state, module_en); end
    end
    scan = 1'b0;
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL scan_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_force_in_drain();
    go_on();
    step(); step();
    checks++; if (clk_state !== S_DRAIN) begin errs++; $display("FAIL fdrain_pre got=%b exp=11", clk_state); end
    scan = 1'b1;
    step();
    scan = 1'b0;
    checks++; if (clk_state !== S_ON) begin errs++; $display("FAIL fdrain_on got=%b exp=10", clk_state); end
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL fdrain_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_reset_mid_wake();
    wake_req = 1'b1;
    step();
    checks++; if (clk_state !== S_WAKE) begin errs++; $display("FAIL rstwake_pre got=%b exp=01", clk_state); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wake_req = 1'b0;
    exp_perf = 0;
    checks++; if (clk_state !== S_ON || wake_ack !== 1'b1 || perf !== 16'd0)
      begin errs++; $display("FAIL rstwake_on got state=%b ack=%b perf=%0d exp 10/1/0", clk_state, wake_ack, perf); end
    drain_to_off();
    exp_perf++;
    checks++; if (clk_state !== S_OFF || perf !== 16'(exp_perf))
      begin errs++; $display("FAIL rstwake_off got state=%b perf=%0d exp 00/%0d", clk_state, perf, exp_perf); end
  endtask

  task automatic test_saturation();
    int exp_sat;
    sat_busy = 1'b1;
    sat_rst  = 1'b0;
    step();
    checks++; if (sat_state !== S_ON || sat_perf !== 4'd0 || sat_ack !== 1'b1)
      begin errs++; $display("FAIL sat_start got state=%b perf=%0d ack=%b exp 10/0/1", sat_state, sat_perf, sat_ack); end
    for (int i = 0; i < 20; i++) begin
      sat_busy = 1'b0;
      step(); step();
      exp_sat = (i + 1 > 15) ? 15 : i + 1;
      checks++; if (sat_state !== S_OFF || sat_men !== 1'b0 || sat_perf !== 4'(exp_sat))
        begin errs++; $display("FAIL sat_count ev=%0d got state=%b men=%b perf=%0d exp 00/0/%0d", i, sat_state, sat_men, sat_perf, exp_sat); end
      sat_busy = 1'b1;
      step(); step();
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; scan = 1'b0; busy = 1'b0; wake_req = 1'b0;
    sat_rst = 1'b1; sat_busy = 1'b1;
    test_reset();
    test_gate_off();
    test_wake();
    test_busy_pulse();
    test_busy_at_expiry();
    test_wake_no_abort();
    test_force_csr();
    test_scan();
    test_force_in_drain();
    test_reset_mid_wake();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
